// File: rtl/packet_split_pkg.sv
// Shared defaults, destination encoding and sizing helper for the
// two-channel packet splitter.
package packet_split_pkg;

  localparam int unsigned DEF_WIDTH = 33;
  localparam int unsigned DEF_DEPTH = 4;

  // Value of the destination bit in a packet
  typedef enum logic {
    DEST_O0 = 1'b0,
    DEST_O1 = 1'b1
  } dest_e;

  // Bits needed to hold an occupancy of 0..depth
  function automatic int unsigned cnt_bits(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/packet_split_2channel_fifo.sv
// split_fifo: single-clock FIFO used as one output buffer of the splitter.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// Push is ignored when full and pop is ignored when empty.
module split_fifo
  import packet_split_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = cnt_bits(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = i_push & ~w_full;
  assign w_pop   = i_pop & ~w_empty;

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy; reset empties the FIFO immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/packet_split_2channel.sv
// packet_split_2channel: routes each input packet to one of two output
// FIFOs by in_data[DEST_BIT]. Define PACKET_SPLIT_BROADCAST_EN to make
// packets with in_data[BCAST_BIT]=1 go to both FIFOs at the same edge.
module packet_split_2channel
  import packet_split_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned DEST_BIT  = WIDTH - 1,
  parameter int unsigned BCAST_BIT = WIDTH - 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           o0_data,
  output logic                       o0_valid,
  input  logic                       o0_ready,
  output logic [$clog2(DEPTH+1)-1:0] o0_count,
  output logic [WIDTH-1:0]           o1_data,
  output logic                       o1_valid,
  input  logic                       o1_ready,
  output logic [$clog2(DEPTH+1)-1:0] o1_count
);

  // Reject impossible configurations at elaboration
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (DEST_BIT >= WIDTH) || (BCAST_BIT >= WIDTH)) begin : g_bad_params
    $error("packet_split_2channel: illegal DEPTH/DEST_BIT/BCAST_BIT");
  end

  dest_e w_dest;
  logic  w_bcast;
  logic  w_accept;
  logic  w_push0;
  logic  w_push1;
  logic  w_full0;
  logic  w_full1;
  logic  w_empty0;
  logic  w_empty1;

  assign w_dest = dest_e'(in_data[DEST_BIT]);

`ifdef PACKET_SPLIT_BROADCAST_EN
  assign w_bcast = in_data[BCAST_BIT];
`else
  assign w_bcast = 1'b0;
`endif

  // Accept only when every targeted FIFO has room; consumer ready is not used
  always_comb begin
    in_ready = 1'b0;
    w_push0  = 1'b0;
    w_push1  = 1'b0;
    if (w_bcast) begin
      in_ready = ~w_full0 & ~w_full1;
    end else if (w_dest == DEST_O1) begin
      in_ready = ~w_full1;
    end else begin
      in_ready = ~w_full0;
    end
    w_accept = in_valid & in_ready;
    w_push0  = w_accept & (w_bcast | (w_dest == DEST_O0));
    w_push1  = w_accept & (w_bcast | (w_dest == DEST_O1));
  end

  split_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push0),
    .i_data  (in_data),
    .i_pop   (o0_ready),
    .o_data  (o0_data),
    .o_count (o0_count),
    .o_full  (w_full0),
    .o_empty (w_empty0)
  );

  split_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push1),
    .i_data  (in_data),
    .i_pop   (o1_ready),
    .o_data  (o1_data),
    .o_count (o1_count),
    .o_full  (w_full1),
    .o_empty (w_empty1)
  );

  assign o0_valid = ~w_empty0;
  assign o1_valid = ~w_empty1;

endmodule

// File: tb/tb_packet_split_2channel.sv
// Testbench for packet_split_2channel: directed scenarios plus random
// traffic, checked against a queue-based model of the two output FIFOs.
module tb_packet_split_2channel;

  localparam int W  = 33;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  o0_data;
  logic          o0_valid;
  logic          o0_ready;
  logic [CW-1:0] o0_count;
  logic [W-1:0]  o1_data;
  logic          o1_valid;
  logic          o1_ready;
  logic [CW-1:0] o1_count;

  packet_split_2channel dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .o0_data  (o0_data),
    .o0_valid (o0_valid),
    .o0_ready (o0_ready),
    .o0_count (o0_count),
    .o1_data  (o1_data),
    .o1_valid (o1_valid),
    .o1_ready (o1_ready),
    .o1_count (o1_count)
  );

  always #5 clk = ~clk;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] rx0[$];
  bit           rec_rx = 1'b0;
  bit           tog_o0 = 1'b0;
  int           n_err  = 0;
  int           n_chk  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_bcast(input logic [W-1:0] d);
`ifdef PACKET_SPLIT_BROADCAST_EN
    return d[W-2];
`else
    return (d[W-2] & 1'b0);
`endif
  endfunction

  // Room in every FIFO the current packet targets
  function automatic bit exp_ready();
    if (is_bcast(in_data)) return (q0.size() < D) && (q1.size() < D);
    if (in_data[W-1])      return q1.size() < D;
    return q0.size() < D;
  endfunction

  // One clock: check outputs at negedge, then advance the model at posedge
  task automatic cycle(output bit acc);
    bit er;
    @(negedge clk);
    er = exp_ready();
    chk("in_ready", 64'(in_ready), 64'(er));
    chk("o0_valid", 64'(o0_valid), 64'(q0.size() != 0));
    chk("o1_valid", 64'(o1_valid), 64'(q1.size() != 0));
    chk("o0_count", 64'(o0_count), 64'(q0.size()));
    chk("o1_count", 64'(o1_count), 64'(q1.size()));
    if (q0.size() != 0) chk("o0_data", 64'(o0_data), 64'(q0[0]));
    if (q1.size() != 0) chk("o1_data", 64'(o1_data), 64'(q1[0]));
    if (rec_rx && o0_valid && o0_ready) rx0.push_back(o0_data);
    @(posedge clk);
    acc = in_valid && er;
    if (o0_ready && q0.size() != 0) void'(q0.pop_front());
    if (o1_ready && q1.size() != 0) void'(q1.pop_front());
    if (acc) begin
      if (is_bcast(in_data) || !in_data[W-1]) q0.push_back(in_data);
      if (is_bcast(in_data) ||  in_data[W-1]) q1.push_back(in_data);
    end
    #1;
    if (tog_o0) o0_ready = ~o0_ready;
  endtask

  // Present a packet until accepted, bounded
  task automatic send(input logic [W-1:0] d, input string tag);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 40 && !acc; i++) cycle(acc);
    chk({tag, "_accepted"}, 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    logic [W-1:0] d;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; o0_ready = 1'b0; o1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o0_valid", 64'(o0_valid), 64'd0);
    chk("rst_o1_valid", 64'(o1_valid), 64'd0);
    chk("rst_o0_count", 64'(o0_count), 64'd0);
    chk("rst_o1_count", 64'(o1_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    // Single unicast packet to o0, visible one cycle after acceptance
    o0_ready = 1'b1;
    send(33'h0_0000_0055, "p55");
    chk("p55_o0_valid", 64'(o0_valid), 64'd1);
    chk("p55_o0_data",  64'(o0_data),  64'h55);
    chk("p55_o1_valid", 64'(o1_valid), 64'd0);
    idle(2);

    // Fill FIFO 1 with its consumer stalled
    o0_ready = 1'b0; o1_ready = 1'b0;
    for (int i = 0; i < 4; i++) send({1'b1, 32'(32'h100 + i)}, "fill1");
    chk("fill1_count", 64'(o1_count), 64'd4);
    in_valid = 1'b1; in_data = {1'b1, 32'h104};
    cycle(acc);
    chk("fifth_rejected", 64'(acc), 64'd0);
    send(33'h0_0000_0077, "o0_while_o1_full");
    // Pop and offered push on full FIFO 1 at the same edge
    in_valid = 1'b1; in_data = {1'b1, 32'h104}; o1_ready = 1'b1;
    cycle(acc);
    chk("full_pop_no_accept", 64'(acc), 64'd0);
    chk("full_pop_count", 64'(o1_count), 64'd3);
    o1_ready = 1'b0;
    cycle(acc);
    chk("fifth_accepted", 64'(acc), 64'd1);
    chk("fifth_count", 64'(o1_count), 64'd4);
    o0_ready = 1'b1; o1_ready = 1'b1;
    idle(6);

    // Sequenced packets across pointer wrap with a toggling consumer
    rec_rx = 1'b1; tog_o0 = 1'b1; o0_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      send(W'(i), "seq");
      chk("seq_count_le4", 64'(o0_count <= 3'd4), 64'd1);
    end
    tog_o0 = 1'b0; o0_ready = 1'b1;
    idle(6);
    rec_rx = 1'b0;
    chk("seq_rx_size", 64'(rx0.size()), 64'd10);
    for (int i = 0; i < 10 && i < rx0.size(); i++) chk("seq_rx_order", 64'(rx0[i]), 64'(i + 1));

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = {1'($urandom), 32'($urandom)};
      o0_ready = ($urandom_range(0, 3) != 0);
      o1_ready = ($urandom_range(0, 2) == 0);
      cycle(acc);
    end
    in_valid = 1'b0; o0_ready = 1'b1; o1_ready = 1'b1;
    idle(6);

`ifdef PACKET_SPLIT_BROADCAST_EN
    // Broadcast lands in both FIFOs; blocked when FIFO 0 is full
    o0_ready = 1'b0; o1_ready = 1'b0;
    send(33'h0_8000_00AA, "bcast");
    chk("bcast_o0_data", 64'(o0_data), 64'hAA);
    chk("bcast_o1_data", 64'(o1_data), 64'hAA);
    for (int i = 0; i < 3; i++) send(W'(32'h200 + i), "fill0");
    in_valid = 1'b1; in_data = 33'h0_8000_00BB;
    cycle(acc);
    chk("bcast_full_rejected", 64'(acc), 64'd0);
    in_valid = 1'b0; o0_ready = 1'b1; o1_ready = 1'b1;
    idle(6);
`endif

    // Asynchronous reset between edges with three packets buffered
    o0_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(W'(32'h300 + i), "pre_rst");
    chk("pre_rst_count", 64'(o0_count), 64'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_o0_valid", 64'(o0_valid), 64'd0);
    chk("async_rst_o0_count", 64'(o0_count), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    q0.delete(); q1.delete();
    #1 rst_n = 1'b1;
    // First edge after reset release must transfer
    in_valid = 1'b1; in_data = 33'h0_0000_0099;
    cycle(acc);
    chk("first_after_rst", 64'(acc), 64'd1);
    in_valid = 1'b0; o0_ready = 1'b1;
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
